// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/shift, multi-cycle shift-add multiply,
// valid/ready handshake on both sides with a hold-until-accepted result.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  input  logic [2:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [RW-1:0]   r_result;
  logic            r_err;
  logic [RW-1:0]   r_acc;
  logic [RW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]   r_cnt;

  logic            w_accept;
  logic            w_last;
  logic [RW-1:0]   w_alu_res;
  logic            w_alu_err;
  logic [RW-1:0]   w_mul_acc;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign err       = r_err;

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_mul_acc = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (op == OP_MUL) ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle operations; oversized shift amounts naturally shift out to zero
  always_comb begin
    w_alu_res = '0;
    w_alu_err = 1'b0;
    case (op)
      OP_ADD:  w_alu_res = RW'(op1) + RW'(op2);
      OP_SUB:  w_alu_res = RW'(op1) - RW'(op2);
      OP_SHL:  w_alu_res = RW'(op1) << op2;
      OP_SHR:  w_alu_res = RW'(op1 >> op2);
      OP_MUL:  w_alu_res = '0;
      default: w_alu_err = 1'b1;
    endcase
  end

  // Handshake flags follow the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Datapath: operand capture, shift-add iteration, result hold and clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_err    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (op == OP_MUL) begin
              r_acc    <= '0;
              r_mcand  <= RW'(op1);
              r_mplier <= op2;
              r_cnt    <= '0;
            end else begin
              r_result <= w_alu_res;
              r_err    <= w_alu_err;
            end
          end
        end
        S_BUSY: begin
          r_acc    <= w_mul_acc;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (w_last) begin
            r_cnt    <= '0;
            r_result <= w_mul_acc;
            r_err    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_result <= '0;
            r_err    <= 1'b0;
          end
        end
        default: begin
          r_result <= '0;
          r_err    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed table, handshake/reset corner
// sequences and randomized ops against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned RW    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    result;
  logic             err;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  o;
    int          stall;
    logic [15:0] res;
    logic        e;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: operation semantics expressed as plain integer arithmetic
  function automatic void model(input int unsigned a, input int unsigned b, input int unsigned o,
                                output int unsigned res, output bit e);
    e = 1'b0;
    case (o)
      0: res = a + b;
      1: res = (a - b) & 32'hFFFF;
      2: res = (b >= RW) ? 0 : ((a << b) & 32'hFFFF);
      3: res = (b >= WIDTH) ? 0 : (a >> b);
      4: res = a * b;
      default: begin res = 0; e = 1'b1; end
    endcase
  endfunction

  // Issue one op from IDLE (called at a negedge), scramble inputs while busy,
  // optionally stall the consumer, then confirm the return to IDLE.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] o, input int stall, input logic [15:0] exp_res,
                        input logic exp_err, input int exp_lat);
    int guard;
    int lat;
    int ir_low;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    op1 = a; op2 = b; op = o; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    lat = 1;
    ir_low = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) ir_low++;
      in_valid = 1'($urandom_range(0, 1));
      op1 = 8'($urandom); op2 = 8'($urandom); op = 3'($urandom);
      @(negedge clk);
      lat++;
    end
    check({tag, "/out_valid_seen"}, 32'(out_valid), 32'd1);
    if (!in_ready) ir_low++;
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/in_ready_low_cycles"}, 32'(ir_low), 32'(exp_lat));
    check({tag, "/result"}, 32'(result), 32'(exp_res));
    check({tag, "/err"}, 32'(err), 32'(exp_err));
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom_range(0, 1));
      op1 = 8'($urandom); op2 = 8'($urandom); op = 3'($urandom);
      @(negedge clk);
      check({tag, "/stall_out_valid"}, 32'(out_valid), 32'd1);
      check({tag, "/stall_result"}, 32'(result), 32'(exp_res));
      check({tag, "/stall_err"}, 32'(err), 32'(exp_err));
      check({tag, "/stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check({tag, "/idle_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "/idle_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "/idle_result"}, 32'(result), 32'd0);
    check({tag, "/idle_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int unsigned m_res;
    bit          m_err;
    int          cnt;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [2:0]  ro;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op1 = '0; op2 = '0; op = '0;
    repeat (3) @(negedge clk);
    check("reset/in_ready", 32'(in_ready), 32'd1);
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/result", 32'(result), 32'd0);
    check("reset/err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    tbl.push_back('{8'd200, 8'd100, 3'b000, 0, 16'h012C, 1'b0, 1});
    tbl.push_back('{8'hFF,  8'hFF,  3'b000, 0, 16'h01FE, 1'b0, 1});
    tbl.push_back('{8'd3,   8'd5,   3'b001, 0, 16'hFFFE, 1'b0, 1});
    tbl.push_back('{8'h80,  8'd7,   3'b011, 0, 16'h0001, 1'b0, 1});
    tbl.push_back('{8'h80,  8'd8,   3'b011, 0, 16'h0000, 1'b0, 1});
    tbl.push_back('{8'hFF,  8'd4,   3'b010, 0, 16'h0FF0, 1'b0, 1});
    tbl.push_back('{8'hFF,  8'd15,  3'b010, 0, 16'h8000, 1'b0, 1});
    tbl.push_back('{8'hFF,  8'd16,  3'b010, 0, 16'h0000, 1'b0, 1});
    tbl.push_back('{8'd255, 8'd255, 3'b100, 0, 16'hFE01, 1'b0, 9});
    tbl.push_back('{8'h5A,  8'd0,   3'b100, 0, 16'h0000, 1'b0, 9});
    tbl.push_back('{8'd17,  8'd13,  3'b100, 2, 16'h00DD, 1'b0, 9});
    tbl.push_back('{8'h12,  8'h34,  3'b110, 0, 16'h0000, 1'b1, 1});
    tbl.push_back('{8'h12,  8'h34,  3'b101, 0, 16'h0000, 1'b1, 1});
    tbl.push_back('{8'hAB,  8'hCD,  3'b111, 1, 16'h0000, 1'b1, 1});
    tbl.push_back('{8'd200, 8'd100, 3'b000, 5, 16'h012C, 1'b0, 1});
    foreach (tbl[i]) begin
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].o, tbl[i].stall,
             tbl[i].res, tbl[i].e, tbl[i].lat);
    end

    // Reset mid-multiply discards the in-flight product
    op1 = 8'd17; op2 = 8'd13; op = 3'b100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy/in_ready_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy/in_ready", 32'(in_ready), 32'd1);
    check("rst_busy/out_valid", 32'(out_valid), 32'd0);
    check("rst_busy/result", 32'(result), 32'd0);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("rst_busy/no_result", 32'(cnt), 32'd0);
    run_op("rst_busy_add", 8'd1, 8'd1, 3'b000, 0, 16'h0002, 1'b0, 1);

    // Reset while a result is stalled in DONE
    out_ready = 1'b0;
    op1 = 8'd5; op2 = 8'd6; op = 3'b000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_done/out_valid", 32'(out_valid), 32'd1);
    check("rst_done/result", 32'(result), 32'd11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    check("rst_done/out_valid_after", 32'(out_valid), 32'd0);
    check("rst_done/in_ready_after", 32'(in_ready), 32'd1);
    check("rst_done/result_after", 32'(result), 32'd0);

    // Reset wins over a simultaneous accept
    rst = 1'b1; in_valid = 1'b1; op1 = 8'd9; op2 = 8'd9; op = 3'b000;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("rst_accept/out_valid", 32'(out_valid), 32'd0);
    check("rst_accept/in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("rst_accept/out_valid_next", 32'(out_valid), 32'd0);

    // Back-to-back single-cycle ops: one result every two cycles
    op1 = 8'd10; op2 = 8'd20; op = 3'b000; in_valid = 1'b1;
    cnt = 0;
    m_res = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        cnt++;
        if (result != 16'd30) m_res++;
      end
    end
    in_valid = 1'b0;
    check("b2b/result_count", 32'(cnt), 32'd10);
    check("b2b/bad_results", 32'(m_res), 32'd0);
    @(negedge clk);

    // Randomized ops against the reference model
    for (int n = 0; n < 200; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      ro = 3'($urandom_range(0, 7));
      model(32'(ra), 32'(rb), 32'(ro), m_res, m_err);
      run_op($sformatf("rand%0d", n), ra, rb, ro, int'($urandom_range(0, 3)),
             16'(m_res), m_err, (ro == 3'b100) ? 9 : 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits (legal range 2..16).
REQ-002 Derived: RW = 2*WIDTH, result width.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand/op bundle valid.
REQ-007 in_ready  output  1  block can accept a bundle.
REQ-008 op1  input  WIDTH  unsigned operand A.
REQ-009 op2  input  WIDTH  unsigned operand B / shift amount.
REQ-010 op  input  3  operation select: 000 add, 001 sub, 010 shl, 011 shr, 100 mul, 101-111 illegal.
REQ-011 out_valid  output  1  result bundle valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  RW  operation result.
REQ-014 err  output  1  illegal op flag, qualified by out_valid.

Function
REQ-015 FSM states: IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept = in_valid && in_ready at a rising edge; op1, op2, op SHALL be captured at accept and ignored otherwise.
REQ-017 IDLE -> DONE on accept of op 000/001/010/011/101-111; result and err registered at the accepting edge (latency 1, out_valid high the following cycle).
REQ-018 IDLE -> BUSY on accept of op 100; multiply by shift-add, one op2 bit per BUSY cycle, iteration counter 0..WIDTH-1.
REQ-019 BUSY -> DONE after exactly WIDTH BUSY cycles; out_valid SHALL first be high WIDTH+1 cycles after the accepting edge.
REQ-020 DONE: out_valid=1; result and err SHALL hold stable until out_valid && out_ready; DONE -> IDLE on that edge.
REQ-021 No same-cycle accept in DONE; back-to-back single-cycle ops give one result per 2 cycles.
REQ-022 add: result = zero-extend(op1) + zero-extend(op2), never wraps.
REQ-023 sub: result = (zero-extend(op1) - zero-extend(op2)) mod 2^RW (two's-complement wrap when op2 > op1).
REQ-024 shl: result = zero-extend(op1) << op2; op2 >= RW SHALL give 0.
REQ-025 shr: result = op1 >> op2 (logical); op2 >= WIDTH SHALL give 0.
REQ-026 mul: result = op1 * op2 unsigned, full RW bits, no truncation.
REQ-027 illegal op: result = 0, err = 1; err = 0 for all legal ops.
REQ-028 out_valid SHALL be 0 in IDLE and BUSY; result/err undefined-but-stable when out_valid=0 is not permitted: they SHALL read 0 in IDLE.
REQ-029 in_valid toggling, op1/op2 changes while in BUSY or DONE SHALL NOT affect the pending result.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, counter 0, out_valid 0, result 0, err 0, in_ready 1 on the next cycle.
REQ-031 rst SHALL take priority over accept, iteration and output handshake in the same cycle.
REQ-032 rst during BUSY or DONE SHALL discard the in-flight operation; no result is ever presented for it.

Verification (WIDTH=8, out_ready=1 unless stated)
REQ-033 add 200+100 -> out_valid one cycle after accept, result 0x012C, err 0.
REQ-034 sub 3-5 -> result 0xFFFE; shr 0x80>>7 -> 0x0001; shr by 8 -> 0x0000.
REQ-035 shl 0xFF<<4 -> 0x0FF0; shl by 16 -> 0x0000.
REQ-036 mul 255*255 -> in_ready low 9 cycles, out_valid 9 cycles after accept, result 0xFE01; mul x*0 -> 0x0000.
REQ-037 out_ready held 0 for 5 cycles in DONE -> result/out_valid stable, in_ready 0, in_valid pulses ignored; release -> IDLE next cycle.
REQ-038 op=110 -> result 0, err 1; rst asserted mid-BUSY of mul 17*13 -> IDLE next cycle, no out_valid for that op, following add 1+1 -> 0x0002.
